gate_exhaustive_checker: RTL and testbench
==========================================

// Module: gate_exhaustive_checker
// PURPOSE
//  Self-contained hardware tester for an N_IN-input combinational gate.
//  Drives every input vector 0..2**N_IN-1 onto the gate and samples its
//  output after a settle time. Compares each sample against the truth
//  table in FUNC and reports an error count, the first failing vector,
//  and a pass flag.
//  Sits on the far side of the gate's a/b/y interface: it drives the inputs
//  and reads the output, on-chip or in a bench harness.
// PARAMETERS
//  N_IN        2        number of gate inputs (1..8)
//  FUNC        4'b1000  truth table, width 2**N_IN; FUNC[v] = expected y for stim=v (default AND)
//  SETTLE_CYC  1        cycles stim is held before sampling dut_y (>=1)
//  ERR_W       8        width of err_count
// PORTS
//  clk              in   1      rising-edge clock
//  rst_n            in   1      asynchronous active-low reset
//  start            in   1      start a sweep; sampled only in IDLE
//  stim             out  N_IN   vector driven to gate inputs (bit0 = a, bit1 = b, ...)
//  dut_y            in   1      gate output under test
//  busy             out  1      high from cycle after accepted start through DONE
//  done             out  1      single-cycle pulse at end of sweep
//  pass             out  1      1 = last completed sweep had zero mismatches; held
//  err_count        out  ERR_W  mismatches in current/last sweep, saturating
//  first_fail_vec   out  N_IN   stim value of first mismatch in last sweep
//  first_fail_valid out  1      first_fail_vec holds a valid value
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, stim=0, busy=0, done=0, pass=0,
//   err_count=0, first_fail_vec=0, first_fail_valid=0, settle counter=0.
//   Takes effect immediately, including mid-sweep; no sweep resumes after release.
//  FSM: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
//  IDLE:   start=1 at an edge -> SETTLE, stim=0, cnt=0, err_count=0,
//          first_fail_valid=0, pass=0. start=0 -> remain, outputs held.
//  SETTLE: cnt increments each cycle; when cnt==SETTLE_CYC-1 -> SAMPLE. stim stable.
//  SAMPLE: compare dut_y with FUNC[stim]. On mismatch, err_count+1
//          (saturates at 2**ERR_W-1, no wrap).
//          If it is the first mismatch, first_fail_vec=stim and first_fail_valid=1.
//          stim==2**N_IN-1 -> DONE; else stim+1, cnt=0 -> SETTLE.
//  DONE:   done=1 for exactly this cycle. pass=(err_count==0), including any
//          mismatch from the final SAMPLE. Next state is IDLE.
//  busy=1 in SETTLE/SAMPLE/DONE. start while busy is ignored (no restart, no queue).
//  stim holds its final value (2**N_IN-1) in IDLE after a sweep until the next start.
//  Latency: start accepted at edge 0 -> done high in cycle 2**N_IN*(SETTLE_CYC+1)+1.
//  dut_y is sampled only in SAMPLE; X/glitches during SETTLE are ignored.
//  The gate is combinational, so the SETTLE_CYC=1 minimum covers its path.
// TESTING
//  1 DUT=AND, defaults, pulse start -> stim 00,01,10,11, each held 2 cycles;
//    done in cycle 9; pass=1; err_count=0; first_fail_valid=0.
//  2 DUT y stuck-at-0 -> err_count=1, first_fail_vec=2'b11,
//    first_fail_valid=1, pass=0.
//  3 DUT=NAND -> err_count=4, first_fail_vec=2'b00, pass=0; rerun with
//    AND -> counters cleared on start, pass=1.
//  4 start re-pulsed in cycle 3 -> ignored, done still in cycle 9; rst_n=0
//    in cycle 5 -> busy/stim/err_count=0 immediately, no done pulse.
//  5 ERR_W=1 with NAND DUT -> err_count saturates at 1, pass=0.
//  6 FUNC=4'b0110, SETTLE_CYC=3, DUT=XOR -> stim held 4 cycles each,
//    done in cycle 17, pass=1.

Source files
------------

// File: rtl/gate_exhaustive_checker.sv
// Exhaustive tester for an N_IN-input combinational gate: walks every input
// vector, samples the gate output after a settle time and checks it against FUNC.
module gate_exhaustive_checker #(
    parameter int                    N_IN       = 2,
    parameter logic [(1<<N_IN)-1:0]  FUNC       = 4'b1000,
    parameter int                    SETTLE_CYC = 1,
    parameter int                    ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   stim,
    input  logic              dut_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid
);

    localparam int              CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0]  LAST_VEC    = {N_IN{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;

    // Handshake: start is a request level looked at only while busy is low;
    // a start seen at an edge in IDLE is accepted, any start while busy is dropped.

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_SETTLE;
            ST_SETTLE: if (cnt == SETTLE_LAST) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = (stim == LAST_VEC) ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // The compare result already folds in the current vector so the final
    // sample's mismatch is reflected in pass when done is raised.
    always_comb begin
        mismatch = (dut_y != FUNC[stim]);
        err_next = err_count;
        if (mismatch && (err_count != ERR_MAX)) begin
            err_next = err_count + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim             <= '0;
            cnt              <= '0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        stim             <= '0;
                        cnt              <= '0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        pass             <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt != SETTLE_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    err_count <= err_next;
                    if (mismatch && !first_fail_valid) begin
                        first_fail_vec   <= stim;
                        first_fail_valid <= 1'b1;
                    end
                    if (stim == LAST_VEC) begin
                        pass <= (err_next == '0);
                    end else begin
                        stim <= stim + N_IN'(1);
                        cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Bench for gate_exhaustive_checker: three instances (defaults, ERR_W=1,
// XOR table with SETTLE_CYC=3) checked every cycle against a timeline model.
module tb_gate_exhaustive_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   gate_mode = 0;   // 0 AND, 1 stuck-at-0, 2 NAND, 3 XOR

    always #5 clk = ~clk;

    logic [1:0] stim0, stim1, stim2;
    logic       y0, y1, y2;
    logic       busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
    logic [7:0] err0, err2;
    logic [0:0] err1;
    logic [1:0] ffv0, ffv1, ffv2;
    logic       ffok0, ffok1, ffok2;

    int total = 0;
    int bad = 0;

    function automatic logic gate_out(input int mode, input logic [1:0] v);
        case (mode)
            0:       return v[0] & v[1];
            1:       return 1'b0;
            2:       return ~(v[0] & v[1]);
            default: return v[0] ^ v[1];
        endcase
    endfunction

    assign y0 = gate_out(gate_mode, stim0);
    assign y1 = gate_out(gate_mode, stim1);
    assign y2 = gate_out(3, stim2);

    gate_exhaustive_checker u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim0), .dut_y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_valid(ffok0)
    );

    gate_exhaustive_checker #(.ERR_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_valid(ffok1)
    );

    gate_exhaustive_checker #(.FUNC(4'b0110), .SETTLE_CYC(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim2), .dut_y(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_vec(ffv2), .first_fail_valid(ffok2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: cycles since the accepted start, per instance
    int         settle_of[3] = '{1, 1, 3};
    logic [3:0] func_of[3]   = '{4'b1000, 4'b1000, 4'b0110};
    int         errmax_of[3] = '{255, 1, 255};
    int         t[3]         = '{0, 0, 0};
    int         mode_at[3]   = '{0, 0, 3};

    function automatic int sweep_len(input int i);
        return 4 * (settle_of[i] + 1);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                t[i] = 0;
            end else if (t[i] == 0 || t[i] >= sweep_len(i) + 2) begin
                if (start) begin
                    t[i] = 1;
                    mode_at[i] = (i == 2) ? 3 : gate_mode;
                end
            end else begin
                t[i]++;
            end
        end
    end

    task automatic model_expect(input int i, output logic b, output logic d, output logic p,
                                output logic fok, output logic [1:0] s,
                                output logic [1:0] fvec, output logic [7:0] e);
        int per, len, c, errs;
        logic [3:0] tab;
        b = 0; d = 0; p = 0; fok = 0; s = 0; fvec = 0; e = 0;
        if (t[i] != 0 && rst_n) begin
            per  = settle_of[i] + 1;
            len  = 4 * per;
            tab  = func_of[i];
            b    = (t[i] <= len + 1);
            d    = (t[i] == len + 1);
            s    = (t[i] <= len) ? 2'((t[i] - 1) / per) : 2'd3;
            c    = (t[i] - 1) / per;
            if (c > 4) c = 4;
            errs = 0;
            for (int v = 0; v < c; v++) begin
                if (gate_out(mode_at[i], 2'(v)) != tab[v]) begin
                    errs++;
                    if (!fok) begin
                        fok  = 1;
                        fvec = 2'(v);
                    end
                end
            end
            e = 8'((errs > errmax_of[i]) ? errmax_of[i] : errs);
            p = (t[i] >= len + 1) && (errs == 0);
        end
    endtask

    task automatic get_act(input int i, output logic b, output logic d, output logic p,
                           output logic fok, output logic [1:0] s,
                           output logic [1:0] fvec, output logic [7:0] e);
        case (i)
            0: begin b = busy0; d = done0; p = pass0; fok = ffok0; s = stim0; fvec = ffv0; e = err0; end
            1: begin b = busy1; d = done1; p = pass1; fok = ffok1; s = stim1; fvec = ffv1; e = {7'd0, err1}; end
            default: begin b = busy2; d = done2; p = pass2; fok = ffok2; s = stim2; fvec = ffv2; e = err2; end
        endcase
    endtask

    always @(negedge clk) begin
        logic ab, ad, ap, afok, eb, ed, ep, efok;
        logic [1:0] as_, afv, es, efv;
        logic [7:0] ae, ee;
        for (int i = 0; i < 3; i++) begin
            get_act(i, ab, ad, ap, afok, as_, afv, ae);
            model_expect(i, eb, ed, ep, efok, es, efv, ee);
            check($sformatf("busy%0d", i), 32'(ab), 32'(eb));
            check($sformatf("done%0d", i), 32'(ad), 32'(ed));
            check($sformatf("pass%0d", i), 32'(ap), 32'(ep));
            check($sformatf("stim%0d", i), 32'(as_), 32'(es));
            check($sformatf("err_count%0d", i), 32'(ae), 32'(ee));
            check($sformatf("ff_valid%0d", i), 32'(afok), 32'(efok));
            if (efok || t[i] == 0 || !rst_n)
                check($sformatf("ff_vec%0d", i), 32'(afv), 32'(efv));
        end
    end

    // ---------------- directed driver
    task automatic pulse_start();
        @(negedge clk); #2 start = 1'b1;
        @(negedge clk); #2 start = 1'b0;
    endtask

    function automatic logic done_of(input int i);
        case (i)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    task automatic wait_done(input int i, input int k0, input int exp_cycle);
        int k;
        k = k0;
        while (!done_of(i) && k < 100) begin
            @(negedge clk); #2;
            k++;
        end
        check($sformatf("done_cycle%0d", i), 32'(k), 32'(exp_cycle));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int dcnt;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy0), 0);
        check("rst_pass", 32'(pass0), 0);
        check("rst_err", 32'(err0), 0);
        check("rst_stim", 32'(stim0), 0);
        #1 rst_n = 1'b1;

        // AND gate, matching table
        gate_mode = 0;
        pulse_start();
        check("and_stim_c1", 32'(stim0), 0);
        wait_done(0, 1, 9);
        check("and_pass", 32'(pass0), 1);
        check("and_err", 32'(err0), 0);
        check("and_ffok", 32'(ffok0), 0);
        idle_cycles(20);
        check("and_stim_hold", 32'(stim0), 3);

        // stuck-at-0 output
        gate_mode = 1;
        pulse_start();
        wait_done(0, 1, 9);
        check("sa0_err", 32'(err0), 1);
        check("sa0_ffv", 32'(ffv0), 3);
        check("sa0_ffok", 32'(ffok0), 1);
        check("sa0_pass", 32'(pass0), 0);
        idle_cycles(20);

        // NAND gate, also exercises ERR_W=1 saturation
        gate_mode = 2;
        pulse_start();
        wait_done(0, 1, 9);
        check("nand_err", 32'(err0), 4);
        check("nand_ffv", 32'(ffv0), 0);
        check("nand_pass", 32'(pass0), 0);
        check("sat_err", 32'(err1), 1);
        check("sat_pass", 32'(pass1), 0);
        idle_cycles(20);

        gate_mode = 0;
        pulse_start();
        check("rerun_err_clr", 32'(err0), 0);
        check("rerun_ffok_clr", 32'(ffok0), 0);
        wait_done(0, 1, 9);
        check("rerun_pass", 32'(pass0), 1);
        idle_cycles(20);

        // start re-pulsed while busy is ignored
        gate_mode = 2;
        pulse_start();
        @(negedge clk);
        @(negedge clk); #2 start = 1'b1;
        @(negedge clk); #2 start = 1'b0;
        wait_done(0, 4, 9);
        check("restart_err", 32'(err0), 4);
        idle_cycles(20);

        // reset mid-sweep
        pulse_start();
        repeat (4) @(negedge clk);
        check("pre_rst_err", 32'(err0), 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy0), 0);
        check("midrst_stim", 32'(stim0), 0);
        check("midrst_err", 32'(err0), 0);
        check("midrst_busy2", 32'(busy2), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        dcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done0 || done1 || done2) dcnt++;
        end
        check("no_done_after_rst", 32'(dcnt), 0);

        // XOR table with longer settle
        gate_mode = 0;
        pulse_start();
        wait_done(2, 1, 17);
        check("xor_pass", 32'(pass2), 1);
        check("xor_err", 32'(err2), 0);
        idle_cycles(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
